// File: rtl/jtkcpu_intctrl.sv
// Interrupt front end for the KCPU core: pin synchronizers, NMI edge capture,
// NMI > FIRQ > IRQ arbitration, acknowledge vectoring and SYNC wake-up.
module jtkcpu_intctrl (
   input  logic        rst,
   input  logic        clk,
   input  logic        cen,
   input  logic        nirq,
   input  logic        nfirq,
   input  logic        nnmi,
   input  logic [7:0]  cc,
   input  logic        s_wr,
   input  logic        sync,
   input  logic        int_ack,
   output logic        nmi,
   output logic        firq,
   output logic        irq,
   output logic [15:0] int_vec,
   output logic        wake
);

   localparam int unsigned VW = 16;
   localparam logic [VW-1:0] VEC_RST  = 16'hFFFE;
   localparam logic [VW-1:0] VEC_NMI  = 16'hFFFC;
   localparam logic [VW-1:0] VEC_FIRQ = 16'hFFF6;
   localparam logic [VW-1:0] VEC_IRQ  = 16'hFFF8;
   localparam int unsigned FIRQ_MASK_BIT = 6;
   localparam int unsigned IRQ_MASK_BIT  = 4;

   logic [1:0] nmi_sync, firq_sync, irq_sync;
   logic       nmi_last;
   logic       armed;
   logic       nmi_pend;
   logic       woken;

   logic nmi_s_c, firq_s_c, irq_s_c;
   logic nmi_edge_c, nmi_req_c, firq_req_c, irq_req_c;
   logic ack_c, any_low_c, nmi_pend_nx_c;
   logic unused_cc;

   assign unused_cc = ^{cc[7], cc[5], cc[3:0]};

   assign nmi_s_c  = nmi_sync[1];
   assign firq_s_c = firq_sync[1];
   assign irq_s_c  = irq_sync[1];

   // Request terms: NMI is edge-latched, FIRQ/IRQ are masked levels
   always_comb begin
      nmi_edge_c    = armed & nmi_last & ~nmi_s_c;
      nmi_req_c     = nmi_pend | nmi_edge_c;
      firq_req_c    = ~firq_s_c & ~cc[FIRQ_MASK_BIT];
      irq_req_c     = ~irq_s_c  & ~cc[IRQ_MASK_BIT];
      ack_c         = int_ack & (nmi | firq | irq);
      any_low_c     = ~nmi_s_c | ~firq_s_c | ~irq_s_c;
      nmi_pend_nx_c = nmi_pend;
      if (nmi_edge_c)
         nmi_pend_nx_c = 1'b1;
      else if (ack_c && nmi)
         nmi_pend_nx_c = 1'b0;
   end

   // Two-flop synchronizers plus the previous synchronized NMI for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nmi_sync  <= 2'b11;
         firq_sync <= 2'b11;
         irq_sync  <= 2'b11;
         nmi_last  <= 1'b1;
      end else if (cen) begin
         nmi_sync  <= {nmi_sync[0],  nnmi};
         firq_sync <= {firq_sync[0], nfirq};
         irq_sync  <= {irq_sync[0],  nirq};
         nmi_last  <= nmi_s_c;
      end
   end

   // NMI is only honoured once the stack pointer has been loaded
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         armed    <= 1'b0;
         nmi_pend <= 1'b0;
      end else if (cen) begin
         if (s_wr) armed <= 1'b1;
         nmi_pend <= nmi_pend_nx_c;
      end
   end

   // One-hot request outputs; an accepted ack blanks them for one cen cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nmi     <= 1'b0;
         firq    <= 1'b0;
         irq     <= 1'b0;
         int_vec <= VEC_RST;
      end else if (cen) begin
         if (ack_c) begin
            nmi  <= 1'b0;
            firq <= 1'b0;
            irq  <= 1'b0;
            if (nmi)
               int_vec <= VEC_NMI;
            else if (firq)
               int_vec <= VEC_FIRQ;
            else
               int_vec <= VEC_IRQ;
         end else begin
            nmi  <= nmi_req_c;
            firq <= ~nmi_req_c & firq_req_c;
            irq  <= ~nmi_req_c & ~firq_req_c & irq_req_c;
         end
      end
   end

   // Single wake pulse per SYNC episode; masks do not matter here
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wake  <= 1'b0;
         woken <= 1'b0;
      end else if (cen) begin
         if (!sync) begin
            wake  <= 1'b0;
            woken <= 1'b0;
         end else if (!woken && (any_low_c || nmi_pend)) begin
            wake  <= 1'b1;
            woken <= 1'b1;
         end else begin
            wake  <= 1'b0;
         end
      end
   end

endmodule
